// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - circular row store presenting the last ROWS rows as one vertical window
// Tracks frame row index, applies vertical stride, valid/ready handshake and synchronous flush.
module line_window_buffer #(
  parameter int DATA_BITS = 8,
  parameter int W         = 24,
  parameter int K         = 6,
  parameter int H         = 24,
  parameter int ROWS      = 3,
  parameter int STRIDE    = 1
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               flush,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [W*K*DATA_BITS-1:0]           row_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [ROWS*W*K*DATA_BITS-1:0]      rows_o,
  output logic [$clog2(H)-1:0]               win_row_o
);
  localparam int RB  = W*K*DATA_BITS;
  localparam int RIW = $clog2(H);
  localparam int PW  = $clog2(ROWS);
  localparam int FW  = $clog2(ROWS+1);
  localparam int SW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [RB-1:0]  store [ROWS];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  wr_ptr_inc;
  logic [PW-1:0]  win_base;
  logic [FW-1:0]  fill;
  logic [RIW-1:0] row_idx;
  logic [SW-1:0]  stride_cnt;
  logic           accept;
  logic           full_after;
  logic           emit;
  logic           frame_end;

  assign ready_o    = !valid_o || ready_i;
  assign accept     = valid_i && ready_o && !flush;
  assign wr_ptr_inc = (wr_ptr == PW'(ROWS-1)) ? '0 : wr_ptr + 1'b1;
  assign full_after = (fill >= FW'(ROWS-1));
  assign emit       = accept && full_after && (stride_cnt == '0);
  assign frame_end  = (row_idx == RIW'(H-1));

  // win_base latches the oldest slot at emission, so the frame-end pointer reset
  // cannot reorder a window that is still being presented.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROWS; i++) store[i] <= '0;
      wr_ptr     <= '0;
      win_base   <= '0;
      fill       <= '0;
      row_idx    <= '0;
      stride_cnt <= '0;
      valid_o    <= 1'b0;
      win_row_o  <= '0;
    end else begin
      if (accept) store[wr_ptr] <= row_i;
      if (flush) begin
        wr_ptr     <= '0;
        fill       <= '0;
        row_idx    <= '0;
        stride_cnt <= '0;
        valid_o    <= 1'b0;
      end else begin
        if (emit) begin
          valid_o   <= 1'b1;
          win_row_o <= row_idx - RIW'(ROWS-1);
          win_base  <= wr_ptr_inc;
        end else if (ready_i) begin
          valid_o <= 1'b0;
        end
        if (accept) begin
          if (frame_end) begin
            wr_ptr     <= '0;
            fill       <= '0;
            row_idx    <= '0;
            stride_cnt <= '0;
          end else begin
            wr_ptr  <= wr_ptr_inc;
            row_idx <= row_idx + 1'b1;
            if (full_after) begin
              fill       <= FW'(ROWS);
              stride_cnt <= (stride_cnt == SW'(STRIDE-1)) ? '0 : stride_cnt + 1'b1;
            end else begin
              fill <= fill + 1'b1;
            end
          end
        end
      end
    end
  end

  for (genvar j = 0; j < ROWS; j++) begin : g_slot
    logic [PW:0]   sum;
    logic [PW-1:0] sel;
    assign sum = {1'b0, win_base} + (PW+1)'(j);
    assign sel = (sum >= (PW+1)'(ROWS)) ? PW'(sum - (PW+1)'(ROWS)) : sum[PW-1:0];
    assign rows_o[j*RB +: RB] = store[sel];
  end
endmodule

// File: tb/tb_line_window_buffer.sv
// tb/tb_line_window_buffer.sv - scoreboard bench for line_window_buffer
// Stimulus pushes expected windows; monitors pop and compare on each window handshake.
module tb_line_window_buffer;
  localparam int RB = 24*6*8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              a_flush = 0, a_valid_i = 0, a_ready_i = 0;
  logic [RB-1:0]     a_row_i = '0;
  logic              a_ready_o, a_valid_o;
  logic [3*RB-1:0]   a_rows_o;
  logic [4:0]        a_win_row_o;

  logic              b_flush = 0, b_valid_i = 0, b_ready_i = 1;
  logic [RB-1:0]     b_row_i = '0;
  logic              b_ready_o, b_valid_o;
  logic [3*RB-1:0]   b_rows_o;
  logic [2:0]        b_win_row_o;

  line_window_buffer u_dut_a (
    .clk(clk), .resetn(resetn), .flush(a_flush), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .row_i(a_row_i), .valid_o(a_valid_o), .ready_i(a_ready_i), .rows_o(a_rows_o),
    .win_row_o(a_win_row_o)
  );

  line_window_buffer #(.H(8), .ROWS(3), .STRIDE(2)) u_dut_b (
    .clk(clk), .resetn(resetn), .flush(b_flush), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .row_i(b_row_i), .valid_o(b_valid_o), .ready_i(b_ready_i), .rows_o(b_rows_o),
    .win_row_o(b_win_row_o)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int a_win_cnt = 0, b_win_cnt = 0;
  int a_last_row = -1;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always @(posedge clk) cyc++;

  function automatic logic [RB-1:0] rowval(input logic [7:0] b);
    return {(RB/8){b}};
  endfunction

  task automatic chk(input string nm, input logic ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // expected entry: {win_row, slot0 byte, slot1 byte, slot2 byte}
  function automatic logic [31:0] win(input int r, input int b0, input int b1, input int b2);
    return {8'(r), 8'(b0), 8'(b1), 8'(b2)};
  endfunction

  always @(negedge clk) begin
    if (resetn && a_valid_o && a_ready_i) begin
      if (qa.size() == 0) chk("a_unexpected_window", 1'b0, longint'(a_win_row_o), 0);
      else begin
        logic [31:0] e;
        e = qa.pop_front();
        chk("a_win_row", 8'(a_win_row_o) == e[31:24], longint'(a_win_row_o), longint'(e[31:24]));
        for (int j = 0; j < 3; j++) begin
          logic [7:0] eb;
          eb = e[23-8*j -: 8];
          chk($sformatf("a_slot%0d", j), a_rows_o[j*RB +: RB] == rowval(eb),
              longint'(a_rows_o[j*RB +: 32]), longint'(eb));
        end
        a_win_cnt++;
        a_last_row = int'(a_win_row_o);
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && b_valid_o && b_ready_i) begin
      if (qb.size() == 0) chk("b_unexpected_window", 1'b0, longint'(b_win_row_o), 0);
      else begin
        logic [31:0] e;
        e = qb.pop_front();
        chk("b_win_row", 8'(b_win_row_o) == e[31:24], longint'(b_win_row_o), longint'(e[31:24]));
        for (int j = 0; j < 3; j++) begin
          logic [7:0] eb;
          eb = e[23-8*j -: 8];
          chk($sformatf("b_slot%0d", j), b_rows_o[j*RB +: RB] == rowval(eb),
              longint'(b_rows_o[j*RB +: 32]), longint'(eb));
        end
        b_win_cnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_row(input bit sel, input logic [7:0] b);
    int n = 0;
    logic acc;
    if (sel) begin b_valid_i = 1'b1; b_row_i = rowval(b); end
    else begin a_valid_i = 1'b1; a_row_i = rowval(b); end
    do begin
      @(negedge clk);
      acc = sel ? b_ready_o : a_ready_o;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 1'b0, n, 50);
    if (sel) b_valid_i = 1'b0;
    else a_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", a_valid_o == 1'b0, a_valid_o, 0);
    chk("rst_ready_o", a_ready_o == 1'b1, a_ready_o, 1);
    chk("rst_win_row", a_win_row_o == 5'd0, a_win_row_o, 0);
    chk("rst_rows_o", a_rows_o == '0, longint'(a_rows_o[63:0]), 0);
    resetn = 1'b1;
    a_ready_i = 1'b1;
    idle(1);

    // full frame back-to-back, row n = byte n+1
    t0 = cyc;
    for (int r = 0; r < 24; r++) begin
      if (r >= 2) qa.push_back(win(r-2, r-1, r, r+1));
      send_row(1'b0, 8'(r+1));
      if (r < 2) chk("fill_no_window", a_valid_o == 1'b0, a_valid_o, 0);
      if (r == 2) chk("first_window_valid", a_valid_o == 1'b1, a_valid_o, 1);
    end
    chk("throughput_cycles", (cyc - t0) == 24, cyc - t0, 24);
    idle(2);
    chk("frame_window_count", a_win_cnt == 22, a_win_cnt, 22);
    chk("frame_last_win_row", a_last_row == 21, a_last_row, 21);

    // backpressure
    a_ready_i = 1'b0;
    send_row(1'b0, 8'h11);
    send_row(1'b0, 8'h12);
    send_row(1'b0, 8'h13);
    qa.push_back(win(0, 8'h11, 8'h12, 8'h13));
    qa.push_back(win(1, 8'h12, 8'h13, 8'h14));
    a_valid_i = 1'b1;
    a_row_i = rowval(8'h14);
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready_o", a_ready_o == 1'b0, a_ready_o, 0);
      chk("stall_valid_o", a_valid_o == 1'b1, a_valid_o, 1);
      chk("stall_slot0", a_rows_o[0 +: RB] == rowval(8'h11), longint'(a_rows_o[31:0]), 32'h11111111);
      chk("stall_slot2", a_rows_o[2*RB +: RB] == rowval(8'h13), longint'(a_rows_o[2*RB +: 32]), 32'h13131313);
    end
    @(posedge clk); #1;
    a_ready_i = 1'b1;
    @(posedge clk); #1;
    a_valid_i = 1'b0;
    idle(1);

    // flush drops a simultaneous row and restarts the frame
    a_ready_i = 1'b0;
    send_row(1'b0, 8'h15);
    chk("pre_flush_valid", a_valid_o == 1'b1, a_valid_o, 1);
    qa.push_back(win(2, 8'h13, 8'h14, 8'h15));
    a_flush = 1'b1;
    a_valid_i = 1'b1;
    a_row_i = rowval(8'h99);
    a_ready_i = 1'b1;
    @(negedge clk);
    chk("flush_ready_o", a_ready_o == 1'b1, a_ready_o, 1);
    @(posedge clk); #1;
    a_flush = 1'b0;
    a_valid_i = 1'b0;
    chk("flush_valid_o", a_valid_o == 1'b0, a_valid_o, 0);
    send_row(1'b0, 8'h21);
    chk("post_flush_row0", a_valid_o == 1'b0, a_valid_o, 0);
    send_row(1'b0, 8'h22);
    chk("post_flush_row1", a_valid_o == 1'b0, a_valid_o, 0);
    qa.push_back(win(0, 8'h21, 8'h22, 8'h23));
    send_row(1'b0, 8'h23);

    // stream to row 10, then reset with a window pending
    for (int k = 3; k <= 10; k++) begin
      qa.push_back(win(k-2, 8'h21+k-2, 8'h21+k-1, 8'h21+k));
      send_row(1'b0, 8'(8'h21+k));
    end
    idle(1);
    a_ready_i = 1'b0;
    send_row(1'b0, 8'h2C);
    chk("pre_reset_valid", a_valid_o == 1'b1, a_valid_o, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", a_valid_o == 1'b0, a_valid_o, 0);
    chk("async_rst_ready", a_ready_o == 1'b1, a_ready_o, 1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    a_ready_i = 1'b1;
    send_row(1'b0, 8'h41);
    send_row(1'b0, 8'h42);
    chk("post_reset_no_window", a_valid_o == 1'b0, a_valid_o, 0);
    qa.push_back(win(0, 8'h41, 8'h42, 8'h43));
    send_row(1'b0, 8'h43);
    idle(2);

    // stride 2, H 8: two frames
    for (int f = 0; f < 2; f++) begin
      int base;
      base = (f == 0) ? 8'h01 : 8'h51;
      for (int r = 0; r < 8; r++) begin
        if (r == 2 || r == 4 || r == 6) qb.push_back(win(r-2, base+r-2, base+r-1, base+r));
        send_row(1'b1, 8'(base+r));
      end
      idle(2);
      chk("stride_window_count", b_win_cnt == 3*(f+1), b_win_cnt, 3*(f+1));
    end

    idle(2);
    chk("a_queue_drained", qa.size() == 0, qa.size(), 0);
    chk("b_queue_drained", qb.size() == 0, qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
